// File: rtl/cic_interpolator.sv
`default_nettype none
// ============================================================================
// Module   : cic_interpolator
// Purpose  : Five-stage CIC interpolation filter. Accepts signed 12-bit
//            samples at the low rate through a valid/ready handshake. It runs
//            five comb stages once per rate slot, zero-stuffs by
//            INTERPOLATION_RATIO and runs five integrators every clock. One
//            scaled signed 12-bit sample leaves every clock.
// Ports    : clk        - sole clock, rising edge
//            rst_n      - asynchronous active-low reset
//            Gain       - output scaling, shift = WIDTH-12-Gain (clamped at 0)
//            d_in       - signed 12-bit input sample
//            in_valid   - d_in is valid
//            in_ready   - block can accept d_in this cycle
//            d_out      - signed 12-bit output sample, one per clock
//            out_valid  - d_out carries filtered data (sticky until reset)
//            underrun   - one-clock pulse when a rate slot found no sample
// Revision : 1.0 - initial release
// ============================================================================
module cic_interpolator #(
    parameter int WIDTH               = 64,
    parameter int INTERPOLATION_RATIO = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  Gain,
    input  logic [11:0] d_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] d_out,
    output logic        out_valid,
    output logic        underrun
);

    localparam int                 c_N         = 5;
    localparam int                 c_CNT_W     = $clog2(INTERPOLATION_RATIO);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(INTERPOLATION_RATIO - 1);
    localparam logic [7:0]         c_MAX_SHIFT = 8'(WIDTH - 12);

    logic [c_CNT_W-1:0]       r_cnt;
    logic                     w_strobe;
    logic signed [WIDTH-1:0]  r_hold;
    logic                     r_hold_full;
    logic                     w_xfer;
    logic signed [WIDTH-1:0]  w_c [0:c_N];
    logic signed [WIDTH-1:0]  r_z [1:c_N];
    logic signed [WIDTH-1:0]  r_comb_out;
    logic signed [WIDTH-1:0]  w_u;
    logic signed [WIDTH-1:0]  r_i [1:c_N];
    logic [7:0]               w_shift;
    logic [11:0]              r_d_out;
    logic                     r_out_valid;
    logic                     r_underrun;
    // Tracks a real sample from comb_out through the five integrators to d_out.
    logic [c_N:0]             r_vpipe;

    // ------------------------------------------------------------------
    // Rate slot timing and single-entry hold register
    // ------------------------------------------------------------------
    assign w_strobe = (r_cnt == c_CNT_MAX);
    // Accepting while the hold is being consumed keeps a continuous source
    // bubble-free.
    assign in_ready = !r_hold_full || w_strobe;
    assign w_xfer   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_strobe) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_xfer) begin
            r_hold      <= {{(WIDTH-12){d_in[11]}}, d_in};
            r_hold_full <= 1'b1;
        end else if (w_strobe) begin
            r_hold_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Comb section: combinational chain, evaluated into registers only at
    // the strobe. An empty hold feeds zero into the chain.
    // ------------------------------------------------------------------
    assign w_c[0] = r_hold_full ? r_hold : '0;

    for (genvar k = 1; k <= c_N; k++) begin : g_comb
        assign w_c[k] = w_c[k-1] - r_z[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= c_N; k++) begin
                r_z[k] <= '0;
            end
            r_comb_out <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_strobe) begin
                for (int k = 1; k <= c_N; k++) begin
                    r_z[k] <= w_c[k-1];
                end
                r_comb_out <= w_c[c_N];
            end
            r_underrun <= w_strobe && !r_hold_full;
        end
    end

    // ------------------------------------------------------------------
    // Zero-stuffer and integrators. comb_out is presented for exactly one
    // clock, the one right after the strobe (cnt == 0). Wrap-around in the
    // integrators is harmless: the comb differences cancel it.
    // ------------------------------------------------------------------
    assign w_u = (r_cnt == '0) ? r_comb_out : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= c_N; k++) begin
                r_i[k] <= '0;
            end
        end else begin
            r_i[1] <= r_i[1] + w_u;
            for (int k = 2; k <= c_N; k++) begin
                r_i[k] <= r_i[k] + r_i[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output scaling and status
    // ------------------------------------------------------------------
    assign w_shift = (Gain > c_MAX_SHIFT) ? 8'd0 : (c_MAX_SHIFT - Gain);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_out     <= '0;
            r_vpipe     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_d_out     <= 12'(r_i[c_N] >>> w_shift);
            r_vpipe     <= {r_vpipe[c_N-1:0], w_strobe && r_hold_full};
            r_out_valid <= r_out_valid || r_vpipe[c_N];
        end
    end

    assign d_out     = r_d_out;
    assign out_valid = r_out_valid;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_cic_interpolator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_interpolator
// Purpose  : Self-checking bench for cic_interpolator. Expected output values
//            are built from the filter's overall impulse response
//            ((1 + z^-1 + ... + z^-(R-1))^5): each sample consumed in a rate
//            slot adds its scaled response into a queue of future outputs,
//            which is popped and compared every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_interpolator;

    localparam int WIDTH = 64;
    localparam int R     = 16;
    localparam int HLEN  = 5 * (R - 1) + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  Gain;
    logic [11:0] d_in;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] d_out;
    logic        out_valid;
    logic        underrun;

    always #5 clk = ~clk;

    cic_interpolator #(
        .WIDTH              (WIDTH),
        .INTERPOLATION_RATIO(R)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Gain     (Gain),
        .d_in     (d_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d_out    (d_out),
        .out_valid(out_valid),
        .underrun (underrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Impulse response of the whole interpolator at the output rate.
    longint h [HLEN];

    // Reference state
    int          m_cnt;
    logic        m_full;
    logic [11:0] m_hold;
    longint      exp_q[$];
    int          e;
    int          ov_at;
    int          m_xfers;
    logic [11:0] exp_d;
    logic        exp_und;
    logic        ready_seen;
    int          xfer_obs;
    int          und_obs;
    logic [11:0] dlog [0:127];

    task automatic model_reset();
        m_cnt      = 0;
        m_full     = 1'b0;
        m_hold     = '0;
        exp_q.delete();
        e          = 0;
        ov_at      = -1;
        exp_d      = '0;
        exp_und    = 1'b0;
        ready_seen = 1'b1;
    endtask

    // One clock: advance the reference on the edge, then compare 1 time unit later.
    task automatic cycle();
        logic   strobe;
        logic   xfer;
        longint y;
        int     sh;
        @(posedge clk);
        e++;
        if (in_valid && ready_seen) xfer_obs++;
        strobe = (m_cnt == R - 1);
        xfer   = in_valid && (!m_full || strobe);
        y      = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sd0;
        sh     = (int'(Gain) > WIDTH - 12) ? 0 : WIDTH - 12 - int'(Gain);
        exp_d  = 12'(y >>> sh);
        exp_und = strobe && !m_full;
        if (strobe && m_full) begin
            // Sample consumed at this edge first reaches d_out six edges later.
            while (exp_q.size() < 5 + HLEN) exp_q.push_back(64'sd0);
            for (int k = 0; k < HLEN; k++)
                exp_q[5 + k] = exp_q[5 + k] + longint'($signed(m_hold)) * h[k];
            if (ov_at < 0) ov_at = e + 6;
        end
        if (xfer) begin
            m_hold = d_in;
            m_full = 1'b1;
            m_xfers++;
        end else if (strobe) begin
            m_full = 1'b0;
        end
        m_cnt = (m_cnt + 1) % R;
        #1;
        check("d_out", d_out, exp_d);
        check("out_valid", out_valid, (ov_at >= 0 && e >= ov_at));
        check("underrun", underrun, exp_und);
        check("in_ready", in_ready, (!m_full || m_cnt == R - 1));
        ready_seen = in_ready;
        if (underrun) und_obs++;
        if (e < 128) dlog[e] = d_out;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_d_out", d_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_underrun", underrun, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        longint tmp [HLEN];
        int     len;
        int     bound;
        logic [11:0] imp [6];

        // Build h as the 5-fold product of an R-tap boxcar.
        for (int i = 0; i < HLEN; i++) h[i] = 0;
        h[0] = 1;
        len  = 1;
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < HLEN; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R; j++)
                    tmp[i + j] = tmp[i + j] + h[i];
            len = len + R - 1;
            for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
        end

        xfer_obs = 0;
        und_obs  = 0;
        m_xfers  = 0;
        for (int i = 0; i < 128; i++) dlog[i] = '0;

        // Reset state
        rst_n    = 1'b0;
        Gain     = 8'd52;
        d_in     = '0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_d_out", d_out, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_underrun", underrun, 0);
        check("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        model_reset();

        // Impulse, shift 0: first strobe ends at edge 16, response at edge 22.
        in_valid = 1'b1;
        d_in     = 12'd1;
        cycle();
        d_in = 12'd0;
        run(110);
        imp = '{12'd1, 12'd5, 12'd15, 12'd35, 12'd70, 12'd126};
        for (int i = 0; i < 6; i++) check("impulse_head", dlog[22 + i], imp[i]);
        check("impulse_before", dlog[21], 0);
        check("impulse_last", dlog[97], 1);
        check("impulse_tail_zero", dlog[98], 0);

        // DC through unity gain (shift 16)
        Gain = 8'd36;
        d_in = 12'd100;
        run(130);
        check("dc_100", d_out, 12'd100);
        d_in = 12'h800;
        run(130);
        check("dc_neg2048", d_out, 12'h800);

        // Reset in the middle of a DC run, then a fresh response
        d_in = 12'd100;
        run(37);
        reset_pulse();
        run(130);
        check("dc_after_reset", d_out, 12'd100);
        check("ov_after_reset", out_valid, 1);

        // Continuous source: one transfer per R clocks and no underrun
        xfer_obs = 0;
        und_obs  = 0;
        run(160);
        check("xfer_per_160", xfer_obs, 10);
        check("no_underrun", und_obs, 0);

        // Random flow control with random data
        Gain = 8'd44;
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            d_in     = 12'($urandom);
            cycle();
        end

        // Gain clamp (shift 0) and maximum shift
        in_valid = 1'b1;
        Gain     = 8'd60;
        for (int i = 0; i < 150; i++) begin
            d_in = 12'($urandom);
            cycle();
        end
        Gain = 8'd0;
        d_in = 12'h800;
        run(130);
        check("gain0_neg", d_out, 12'hFFF);

        // Source stops after 10 samples
        Gain    = 8'd40;
        m_xfers = 0;
        bound   = 0;
        while (m_xfers < 10 && bound < 400) begin
            d_in = 12'($urandom);
            cycle();
            bound++;
        end
        check("ten_samples", m_xfers, 10);
        in_valid = 1'b0;
        run(40);
        und_obs = 0;
        run(160);
        check("underrun_per_160", und_obs, 10);
        check("decay_zero", d_out, 0);
        check("ov_sticky", out_valid, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
